// File: rtl/rbcp_wb_fabric.sv
// RBCP-to-Wishbone fabric: one 8-bit Wishbone cycle per RBCP byte, decoded on RBCP_ADDR[31:16],
// with timeout and unmapped-region error replies. Define RBCP_WB_FABRIC_ERRCNT_EN to add ERR_CNT/ERR_LAST.
module rbcp_wb_fabric #(
  parameter int          N_SLV    = 8,
  parameter logic [15:0] SEL_BASE = 16'h0000,
  parameter int          TIMEOUT  = 255,
  parameter logic [7:0]  ERR_RD   = 8'hFF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RBCP_ACT,
  input  logic [31:0]        RBCP_ADDR,
  input  logic               RBCP_WE,
  input  logic [7:0]         RBCP_WD,
  input  logic               RBCP_RE,
  output logic [7:0]         RBCP_RD,
  output logic               RBCP_ACK,
  output logic               WB_CYC,
  output logic [N_SLV-1:0]   WB_STB,
  output logic               WB_WE,
  output logic [15:0]        WB_ADR,
  output logic [7:0]         WB_DAT_O,
  input  logic [N_SLV*8-1:0] WB_DAT_I,
  input  logic [N_SLV-1:0]   WB_ACK,
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
  output logic [15:0]        ERR_CNT,
  output logic [1:0]         ERR_LAST,
`endif
  output logic               BUSY
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_SLV-1:0] stb_q, stb_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [15:0]      adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       rd_q, rd_d;

  logic        req;
  logic [15:0] region_idx;
  logic        mapped;
  logic        slv_ack;
  logic [7:0]  slv_dat;

  assign req        = (RBCP_WE | RBCP_RE) & RBCP_ACT;
  assign region_idx = RBCP_ADDR[31:16] - SEL_BASE;
  assign mapped     = 32'(region_idx) < N_SLV;
  // Only the strobed slave may acknowledge; stray acks elsewhere are masked off.
  assign slv_ack    = |(WB_ACK & stb_q);

  always_comb begin
    slv_dat = 8'h00;
    for (int i = 0; i < N_SLV; i++) begin
      if (stb_q[i]) slv_dat = slv_dat | WB_DAT_I[8*i +: 8];
    end
  end

  always_comb begin
    // NOTE: every target gets a default before the case, so no latch can be inferred.
    state_d = state_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    rd_d    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d = RBCP_ADDR[15:0];
          dat_d = RBCP_WD;
          we_d  = RBCP_WE;
          cnt_d = 16'd0;
          if (mapped) begin
            stb_d = '0;
            stb_d[region_idx[IDX_W-1:0]] = 1'b1;
            cyc_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            rd_d    = RBCP_WE ? 8'h00 : ERR_RD;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (!RBCP_ACT) begin
          stb_d   = '0;
          cyc_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (slv_ack) begin
          stb_d   = '0;
          cyc_d   = 1'b0;
          rd_d    = we_q ? 8'h00 : slv_dat;
          state_d = ST_RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          stb_d   = '0;
          cyc_d   = 1'b0;
          rd_d    = we_q ? 8'h00 : ERR_RD;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 16'h0000;
      dat_q   <= 8'h00;
      cnt_q   <= 16'd0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign WB_CYC   = cyc_q;
  assign WB_STB   = stb_q;
  assign WB_WE    = we_q;
  assign WB_ADR   = adr_q;
  assign WB_DAT_O = dat_q;
  assign RBCP_ACK = (state_q == ST_RESP);
  assign RBCP_RD  = rd_q;
  assign BUSY     = (state_q != ST_IDLE);

`ifdef RBCP_WB_FABRIC_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [1:0]  err_last_q;
  logic [1:0]  err_kind;

  // Entering RESP straight from IDLE is an unmapped access; from REQ without ack, a timeout.
  assign err_kind = (state_q == ST_IDLE) ? 2'b10 : (slv_ack ? 2'b00 : 2'b01);

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q  <= 16'h0000;
      err_last_q <= 2'b00;
    end else if (state_d == ST_RESP) begin
      err_last_q <= err_kind;
      if (err_kind != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign ERR_CNT  = err_cnt_q;
  assign ERR_LAST = err_last_q;
`endif

endmodule

// File: tb/tb_rbcp_wb_fabric.sv
// Self-checking bench for rbcp_wb_fabric: directed table, randomized vectors against a
// behavioural model, and hand sequences for ACT abort and mid-cycle reset.
module tb_rbcp_wb_fabric;

  localparam int          N_SLV    = 8;
  localparam logic [15:0] SEL_BASE = 16'h0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [7:0]  ERR_RD   = 8'hFF;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               RBCP_ACT = 1'b0;
  logic [31:0]        RBCP_ADDR = '0;
  logic               RBCP_WE = 1'b0;
  logic [7:0]         RBCP_WD = '0;
  logic               RBCP_RE = 1'b0;
  logic [7:0]         RBCP_RD;
  logic               RBCP_ACK;
  logic               WB_CYC;
  logic [N_SLV-1:0]   WB_STB;
  logic               WB_WE;
  logic [15:0]        WB_ADR;
  logic [7:0]         WB_DAT_O;
  logic [N_SLV*8-1:0] WB_DAT_I = '0;
  logic [N_SLV-1:0]   WB_ACK = '0;
  logic               BUSY;
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
  logic [15:0]        ERR_CNT;
  logic [1:0]         ERR_LAST;
  logic [15:0]        err_m = 16'h0000;
`endif

  int total = 0;
  int bad   = 0;

  rbcp_wb_fabric #(
    .N_SLV(N_SLV), .SEL_BASE(SEL_BASE), .TIMEOUT(TIMEOUT), .ERR_RD(ERR_RD)
  ) dut (
    .CLK(CLK), .RST(RST), .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR),
    .RBCP_WE(RBCP_WE), .RBCP_WD(RBCP_WD), .RBCP_RE(RBCP_RE), .RBCP_RD(RBCP_RD),
    .RBCP_ACK(RBCP_ACK), .WB_CYC(WB_CYC), .WB_STB(WB_STB), .WB_WE(WB_WE),
    .WB_ADR(WB_ADR), .WB_DAT_O(WB_DAT_O), .WB_DAT_I(WB_DAT_I), .WB_ACK(WB_ACK),
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
    .ERR_CNT(ERR_CNT), .ERR_LAST(ERR_LAST),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // ack_at = which STB-high cycle the addressed slave acks in (0 = never).
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [7:0]  wd;
    int          ack_at;
    logic [7:0]  dat;
    logic        noise;
    logic        poke;
    int          exp_ack;
    logic [7:0]  exp_rd;
    int          exp_stb;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   region;
    r = v;
    region = int'(16'(v.addr[31:16] - SEL_BASE));
    if (region >= N_SLV) begin
      r.exp_stb = 0;
      r.exp_ack = 1;
      r.exp_rd  = v.we ? 8'h00 : ERR_RD;
      r.exp_err = 2'b10;
    end else if (v.ack_at >= 1 && v.ack_at <= TIMEOUT) begin
      r.exp_stb = v.ack_at;
      r.exp_ack = v.ack_at + 1;
      r.exp_rd  = v.we ? 8'h00 : v.dat;
      r.exp_err = 2'b00;
    end else begin
      r.exp_stb = TIMEOUT;
      r.exp_ack = TIMEOUT + 1;
      r.exp_rd  = v.we ? 8'h00 : ERR_RD;
      r.exp_err = 2'b01;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int               stb_cnt = 0, ack_cnt = 0, ack_cyc = -1;
    int               bad_onehot = 0, bad_stable = 0, bad_rd = 0;
    logic [7:0]       ack_rd = 8'h00;
    logic [15:0]      err_cnt_s = 16'h0000;
    logic [1:0]       err_last_s = 2'b00;
    logic [N_SLV-1:0] sel = '0;
    int               region;
    region = int'(16'(v.addr[31:16] - SEL_BASE));
    if (region < N_SLV) sel[region] = 1'b1;
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_ADDR = v.addr; RBCP_WD = v.wd; RBCP_WE = v.we; RBCP_RE = v.re;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      RBCP_WE = 1'b0; RBCP_RE = 1'b0;
      RBCP_ADDR = $urandom; RBCP_WD = 8'($urandom);
      if (v.poke && c == 1) RBCP_RE = 1'b1;
      if (WB_STB != '0) begin
        stb_cnt++;
        if (WB_STB != sel || !WB_CYC) bad_onehot++;
        if (WB_ADR != v.addr[15:0] || WB_DAT_O != v.wd || WB_WE != v.we) bad_stable++;
      end else if (WB_CYC) bad_onehot++;
      if (RBCP_ACK) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          ack_rd  = RBCP_RD;
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
          err_cnt_s  = ERR_CNT;
          err_last_s = ERR_LAST;
`endif
        end
      end else if (RBCP_RD != 8'h00) bad_rd++;
      WB_DAT_I = {N_SLV{~v.dat}};
      WB_ACK   = v.noise ? ~sel : '0;
      if ((WB_STB & sel) != '0 && stb_cnt == v.ack_at) begin
        WB_ACK = WB_ACK | sel;
        WB_DAT_I[8*region +: 8] = v.dat;
      end
      if (ack_cyc > 0 && c >= ack_cyc + 3) break;
    end
    RBCP_ACT = 1'b0; WB_ACK = '0;
    check({tag, ".ack_cycle"}, ack_cyc, v.exp_ack);
    check({tag, ".rd"}, {24'h0, ack_rd}, {24'h0, v.exp_rd});
    check({tag, ".stb_cycles"}, stb_cnt, v.exp_stb);
    check({tag, ".ack_count"}, ack_cnt, 1);
    check({tag, ".stb_onehot"}, bad_onehot, 0);
    check({tag, ".wb_stable"}, bad_stable, 0);
    check({tag, ".rd_idle_zero"}, bad_rd, 0);
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
    if (v.exp_err != 2'b00 && err_m != 16'hFFFF) err_m++;
    check({tag, ".err_cnt"}, {16'h0, err_cnt_s}, {16'h0, err_m});
    check({tag, ".err_last"}, {30'h0, err_last_s}, {30'h0, v.exp_err});
`else
    err_cnt_s = err_cnt_s + {14'h0, err_last_s};
`endif
  endtask

  task automatic abort_seq();
    int acks = 0;
    vec_t v;
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h0003_0042; RBCP_RE = 1'b1;
    @(negedge CLK);
    RBCP_RE = 1'b0;
    check("abort.stb_c1", {24'h0, WB_STB}, 32'h08);
    @(negedge CLK);
    check("abort.stb_c2", {24'h0, WB_STB}, 32'h08);
    RBCP_ACT = 1'b0;
    @(negedge CLK);
    check("abort.cyc_stb_low", {23'h0, WB_CYC, WB_STB}, 32'h0);
    check("abort.busy_low", {31'h0, BUSY}, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (RBCP_ACK) acks++;
      @(negedge CLK);
    end
    check("abort.no_ack", acks, 0);
    v = '{32'h0003_0042, 1'b0, 1'b1, 8'h00, 2, 8'hC3, 1'b0, 1'b0, 0, 8'h00, 0, 2'b00};
    run_vec(model(v), "abort.follow");
  endtask

  task automatic reset_seq();
    int acks = 0, stbs = 0;
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h0001_00AB; RBCP_WD = 8'h5E; RBCP_WE = 1'b1;
    @(negedge CLK);
    RBCP_WE = 1'b0;
    check("reset.pre_stb", {23'h0, WB_CYC, WB_STB}, {23'h0, 1'b1, 8'h02});
    RST = 1'b1;
    @(negedge CLK);
    check("reset.outputs_zero",
          {WB_CYC, WB_STB, WB_WE, WB_ADR, RBCP_ACK, BUSY},
          32'h0);
    check("reset.data_zero", {16'h0, WB_DAT_O, RBCP_RD}, 32'h0);
`ifdef RBCP_WB_FABRIC_ERRCNT_EN
    err_m = 16'h0000;
    check("reset.err_zero", {14'h0, ERR_CNT, ERR_LAST}, 32'h0);
`endif
    RST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (RBCP_ACK) acks++;
      if (WB_STB != '0) stbs++;
    end
    RBCP_ACT = 1'b0;
    check("reset.no_ack", acks, 0);
    check("reset.no_stb", stbs, 0);
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    tbl[0]  = '{32'h0002_0003, 1'b1, 1'b0, 8'hA5, 2,  8'h00, 1'b0, 1'b0, 3,  8'h00, 2,  2'b00};
    tbl[1]  = '{32'h0005_0010, 1'b0, 1'b1, 8'h00, 3,  8'h3C, 1'b1, 1'b0, 4,  8'h3C, 3,  2'b00};
    tbl[2]  = '{32'h0009_0000, 1'b0, 1'b1, 8'h00, 1,  8'h00, 1'b0, 1'b0, 1,  8'hFF, 0,  2'b10};
    tbl[3]  = '{32'h0000_0001, 1'b0, 1'b1, 8'h00, 0,  8'h00, 1'b1, 1'b0, 17, 8'hFF, 16, 2'b01};
    tbl[4]  = '{32'h0000_0001, 1'b0, 1'b1, 8'h00, 16, 8'h5A, 1'b0, 1'b0, 17, 8'h5A, 16, 2'b00};
    tbl[5]  = '{32'h0000_0000, 1'b1, 1'b0, 8'h42, 0,  8'h00, 1'b0, 1'b0, 17, 8'h00, 16, 2'b01};
    tbl[6]  = '{32'h0007_FFFF, 1'b1, 1'b1, 8'h99, 1,  8'h77, 1'b1, 1'b0, 2,  8'h00, 1,  2'b00};
    tbl[7]  = '{32'hFFFF_0000, 1'b1, 1'b0, 8'h10, 1,  8'h00, 1'b0, 1'b0, 1,  8'h00, 0,  2'b10};
    tbl[8]  = '{32'h0008_0000, 1'b0, 1'b1, 8'h00, 1,  8'h00, 1'b0, 1'b0, 1,  8'hFF, 0,  2'b10};
    tbl[9]  = '{32'h0007_1234, 1'b0, 1'b1, 8'h00, 17, 8'h11, 1'b0, 1'b0, 17, 8'hFF, 16, 2'b01};
    tbl[10] = '{32'h0006_0001, 1'b0, 1'b1, 8'h00, 2,  8'h6E, 1'b0, 1'b1, 3,  8'h6E, 2,  2'b00};
    tbl[11] = '{32'h0001_0002, 1'b0, 1'b1, 8'h00, 1,  8'h81, 1'b1, 1'b0, 2,  8'h81, 1,  2'b00};

    repeat (3) @(negedge CLK);
    check("init.outputs_zero", {WB_CYC, WB_STB, WB_WE, WB_ADR, RBCP_ACK, BUSY}, 32'h0);
    check("init.data_zero", {16'h0, WB_DAT_O, RBCP_RD}, 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.addr   = {16'(SEL_BASE + 16'($urandom_range(0, 11))), 16'($urandom)};
      v.wd     = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       begin v.we = 1'b0; v.re = 1'b1; end
        1:       begin v.we = 1'b1; v.re = 1'b0; end
        default: begin v.we = 1'b1; v.re = 1'b1; end
      endcase
      v.ack_at = $urandom_range(0, 18);
      v.dat    = 8'($urandom);
      v.noise  = 1'($urandom);
      v.poke   = 1'($urandom);
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    abort_seq();
    reset_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbcp_wb_fabric.md
Name: rbcp_wb_fabric

Overview:
Parametrised RBCP-to-Wishbone fabric for the FMC register path. It replaces the fixed five-region chip-select plus bridge arrangement with N_SLV generic 8-bit Wishbone slave ports, decoded on RBCP_ADDR[31:16]. Each RBCP byte access becomes a single Wishbone cycle. The block adds a per-access timeout and an unmapped-region error response, so the SiTCP host never hangs waiting for RBCP_ACK.

Parameters:
N_SLV, 8, number of slave ports (1..16); slave i owns RBCP_ADDR[31:16] == SEL_BASE+i
SEL_BASE, 16'h0000, region index of slave 0
TIMEOUT, 255, cycles STB may stay high without ACK before abort (1..65535)
ERR_RD, 8'hFF, RBCP_RD value returned on timeout or unmapped read

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
RBCP_ACT  in  1  RBCP transaction active
RBCP_ADDR  in  32  RBCP address
RBCP_WE  in  1  write strobe, 1-cycle pulse
RBCP_WD  in  8  write data
RBCP_RE  in  1  read strobe, 1-cycle pulse
RBCP_RD  out  8  read data, valid with RBCP_ACK
RBCP_ACK  out  1  1-cycle acknowledge
WB_CYC  out  1  Wishbone cycle
WB_STB  out  N_SLV  one-hot strobe per slave
WB_WE  out  1  write enable
WB_ADR  out  16  RBCP_ADDR[15:0], latched
WB_DAT_O  out  8  write data, latched
WB_DAT_I  in  N_SLV*8  slave read data, slave i at [8i+7:8i]
WB_ACK  in  N_SLV  slave acknowledges
BUSY  out  1  high from request latch until RBCP_ACK or abort

Behaviour:
- Reset: all outputs 0; FSM to IDLE; timeout counter 0. RST mid-cycle drops CYC/STB at the next edge and emits no RBCP_ACK.
- FSM states: IDLE, REQ, RESP.
- IDLE: on (RBCP_WE|RBCP_RE)&RBCP_ACT in cycle 0:
  - Latch ADDR, WD and WE (WE=RBCP_WE).
  - Compute idx = RBCP_ADDR[31:16]-SEL_BASE, 16-bit modular.
  - idx < N_SLV: go to REQ; CYC=1 and STB[idx]=1 from cycle 1.
  - Otherwise (unmapped): go to RESP directly; RBCP_ACK=1 in cycle 1 with RD=ERR_RD on read, 8'h00 on write.
- IDLE, WE and RE both high: treated as a write.
- REQ:
  - Count cycles with STB high.
  - WB_ACK[idx] sampled at edge k: CYC/STB drop at k+1, RBCP_ACK=1 at k+1, RBCP_RD = WB_DAT_I[idx] (read) or 8'h00 (write). Minimum latency: request cycle 0 to ACK cycle 2.
  - Acks from non-selected slaves are ignored.
  - Counter reaches TIMEOUT with no ack: drop CYC/STB, RBCP_ACK=1 next cycle with RD=ERR_RD (read) or 8'h00 (write).
  - Ack in the same cycle the counter expires: the ack wins and real data is returned.
  - RBCP_ACT falls during REQ: abort; drop CYC/STB next edge, no RBCP_ACK, return to IDLE.
- RESP: one cycle with RBCP_ACK=1, then IDLE. RBCP_RD returns to 8'h00 when ACK is 0.
- New WE/RE while BUSY: ignored, no queuing.
- Consecutive RBCP bytes (address auto-increment) each run a full FSM round trip; back-to-back strobes are accepted from the cycle after RBCP_ACK.
- WB_ADR, WB_DAT_O and WB_WE are stable throughout CYC. STB is exactly one-hot or zero.

Optional Feature:
Macro RBCP_WB_FABRIC_ERRCNT_EN.
- Defined: adds output ERR_CNT (16) and ERR_LAST (2). ERR_CNT is a saturating count of timeouts plus unmapped accesses; it holds at 16'hFFFF. ERR_LAST = 2'b01 timeout, 2'b10 unmapped, 2'b00 none. Both reset to 0 and update in the cycle of the corresponding RBCP_ACK.
- Undefined: ports absent, no counter logic.

Test Plan:
- Write 8'hA5 to 0x0002_0003, N_SLV=8, slave 2 acks 1 cycle after STB -> STB=8'b0000_0100, WB_ADR=16'h0003, WB_DAT_O=8'hA5, WB_WE=1; RBCP_ACK pulses once, 1 cycle after the slave ack.
- Read 0x0005_0010, slave 5 acks after 3 cycles with data 8'h3C -> RBCP_RD=8'h3C with ACK; slave 4 acking simultaneously with 8'hFF is ignored.
- Read 0x0009_0000 with N_SLV=8 -> no STB; RBCP_ACK in cycle 1 with RD=8'hFF; ERR_CNT increments to 1, ERR_LAST=2'b10 (macro on).
- Read slave 0, TIMEOUT=16, slave never acks -> STB high exactly 16 cycles; ACK next cycle with RD=8'hFF; ERR_LAST=2'b01. Repeat with the ack arriving on cycle 16 -> real data returned.
- RBCP_ACT falls 2 cycles into REQ -> CYC/STB low next edge, no RBCP_ACK; a following read completes normally.
- RST asserted during REQ -> all outputs 0 next edge; a second RE during BUSY produces no extra STB.
